// File: rtl/hazard_dest_pipe.sv
// Destination-tag pipeline (EX/MEM/WB) feeding the forwarding units, plus the
// ID-stage hazard detector that stalls for load-use and branch-compare hazards.
module hazard_dest_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rd,
    input  logic        id_we,
    input  logic        id_is_load,
    input  logic        id_is_branch,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_flush,
    output logic [4:0]  ex_rd,
    output logic [4:0]  mem_rd,
    output logic [4:0]  wb_rd,
    output logic        ex_we,
    output logic        mem_we,
    output logic        wb_we,
    output logic        ex_is_load,
    output logic        mem_is_load,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    logic [4:0]  r_ex_rd;
    logic [4:0]  r_mem_rd;
    logic [4:0]  r_wb_rd;
    logic        r_ex_we;
    logic        r_mem_we;
    logic        r_wb_we;
    logic        r_ex_is_load;
    logic        r_mem_is_load;
    logic [15:0] r_stall_cnt;

    logic        w_hot_ex;
    logic        w_hot_mem;
    logic        w_load_use;
    logic        w_branch_ex;
    logic        w_branch_mem;
    logic        w_stall;
    logic        w_bubble;

    // A source only counts if it is actually read, is not $0, and the stage writes it.
    function automatic logic f_hot(input logic       use_src,
                                   input logic [4:0] src,
                                   input logic [4:0] dst,
                                   input logic       dst_we);
        return use_src && (src != 5'd0) && (src == dst) && dst_we;
    endfunction

    assign w_hot_ex  = f_hot(id_use_rs, id_rs, r_ex_rd, r_ex_we)
                     | f_hot(id_use_rt, id_rt, r_ex_rd, r_ex_we);
    assign w_hot_mem = f_hot(id_use_rs, id_rs, r_mem_rd, r_mem_we)
                     | f_hot(id_use_rt, id_rt, r_mem_rd, r_mem_we);

    assign w_load_use   = r_ex_we && r_ex_is_load && w_hot_ex;
    assign w_branch_ex  = id_is_branch && r_ex_we && w_hot_ex;
    assign w_branch_mem = id_is_branch && r_mem_we && r_mem_is_load && w_hot_mem;

    // A flushed instruction is dead, so it can never be the reason to stall.
    assign w_stall  = id_valid && !id_flush && (w_load_use || w_branch_ex || w_branch_mem);
    assign w_bubble = w_stall || id_flush || !id_valid;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage samples the pre-edge value
        // of the stage ahead of it, regardless of statement order.
        if (!rst_n) begin
            r_ex_rd       <= 5'd0;
            r_ex_we       <= 1'b0;
            r_ex_is_load  <= 1'b0;
            r_mem_rd      <= 5'd0;
            r_mem_we      <= 1'b0;
            r_mem_is_load <= 1'b0;
            r_wb_rd       <= 5'd0;
            r_wb_we       <= 1'b0;
            r_stall_cnt   <= 16'd0;
        end else begin
            r_mem_rd      <= r_ex_rd;
            r_mem_we      <= r_ex_we;
            r_mem_is_load <= r_ex_is_load;
            r_wb_rd       <= r_mem_rd;
            r_wb_we       <= r_mem_we;
            if (w_bubble) begin
                r_ex_rd      <= 5'd0;
                r_ex_we      <= 1'b0;
                r_ex_is_load <= 1'b0;
            end else begin
                r_ex_rd      <= id_rd;
                r_ex_we      <= id_we && (id_rd != 5'd0);
                r_ex_is_load <= id_is_load && id_we;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign ex_rd       = r_ex_rd;
    assign ex_we       = r_ex_we;
    assign ex_is_load  = r_ex_is_load;
    assign mem_rd      = r_mem_rd;
    assign mem_we      = r_mem_we;
    assign mem_is_load = r_mem_is_load;
    assign wb_rd       = r_wb_rd;
    assign wb_we       = r_wb_we;
    assign stall       = w_stall;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: doc/hazard_dest_pipe.md
HAZARD_DEST_PIPE -- requirements
Module: hazard_dest_pipe

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-002 The block SHALL have these ports, each with its direction, width and meaning:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rd  in  5  destination register of the ID instruction.
- id_we  in  1  the ID instruction writes id_rd.
- id_is_load  in  1  the ID instruction is a load.
- id_is_branch  in  1  the ID instruction is a beq/bne (compared in ID).
- id_rs, id_rt  in  5 each  source registers of the ID instruction.
- id_use_rs, id_use_rt  in  1 each  the ID instruction reads that source.
- id_flush  in  1  kill the ID instruction (redirect).
- ex_rd, mem_rd, wb_rd  out  5 each  destination register per stage (registered).
- ex_we, mem_we, wb_we  out  1 each  write enable per stage (registered).
- ex_is_load, mem_is_load  out  1 each  load marker per stage (registered).
- stall  out  1  hold PC and IF/ID; insert a bubble into EX (combinational).
- stall_cnt  out  16  count of stall cycles, saturating (registered).

Function
REQ-003 The block SHALL act as the producer of the destination/write-enable tags that the branch and ALU forwarding units consume.
REQ-004 A source is "hot" when all three hold: its use bit is 1, the register is not 0, and it equals the destination of a stage whose we bit is 1.
REQ-005 Load-use stall: stall SHALL be 1 when id_valid=1, ex_we=1 and ex_is_load=1, and a source is hot against ex_rd.
REQ-006 Branch-EX stall: stall SHALL be 1 when id_valid=1, id_is_branch=1 and ex_we=1, and a source is hot against ex_rd. ALU-in-EX also stalls, because the branch compare cannot absorb the ALU path in the same cycle.
REQ-007 Branch-load-MEM stall: stall SHALL be 1 when id_valid=1, id_is_branch=1, mem_we=1 and mem_is_load=1, and a source is hot against mem_rd.
REQ-008 In all other cases stall SHALL be 0. A hit against wb_rd SHALL never stall; it is resolved by forwarding.
REQ-009 stall SHALL be 0 whenever id_flush=1 or id_valid=0.
REQ-010 On each rising edge with rst_n=1, the MEM stage SHALL load the EX tags and the WB stage SHALL load the MEM tags. Each stage carries rd, we and is_load; wb keeps no load marker.
REQ-011 On each rising edge with rst_n=1, the EX stage SHALL load a bubble (rd=0, we=0, is_load=0) if stall=1, id_flush=1 or id_valid=0.
REQ-012 Otherwise the EX stage SHALL load id_rd, id_we & (id_rd!=0) and id_is_load & id_we.
REQ-013 id_flush SHALL take priority over stall. Both conditions insert a bubble, and stall is forced low when id_flush=1.
REQ-014 Stall sequences follow from the rules above:
- Branch after a load with a matching register: 2 consecutive stall cycles.
- Branch after an ALU op: 1 stall cycle.
- Non-branch after a load: 1 stall cycle.
- Non-branch after an ALU op: 0 stall cycles.
REQ-015 stall_cnt SHALL increment by 1 on every edge where stall=1, and SHALL hold at 16'hFFFF once it reaches that value (no wrap).
REQ-016 The tag pipeline SHALL have latency 1 cycle per stage, with no backpressure other than stall.
REQ-017 id_rd=0 SHALL never produce a hot match in any stage.

Reset
REQ-018 While rst_n=0 at a rising edge, all of the following SHALL be 0 after that edge: ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we, ex_is_load, mem_is_load and stall_cnt.
REQ-019 With all stages empty after reset, stall SHALL evaluate to 0.
REQ-020 A reset asserted during a stall sequence SHALL abort it: the pipeline empties and the next ID instruction proceeds without stalling.
REQ-021 Reset SHALL take priority over id_flush and stall in the same cycle.

Verification
REQ-022 The bench SHALL cover load-use: lw $8 then add using rs=$8 -> stall=1 for 1 cycle; ex shows a bubble (we=0); stall_cnt=1; add enters EX next cycle.
REQ-023 The bench SHALL cover branch after load: lw $9 then beq rs=$9 -> stall=1 for exactly 2 cycles; stall_cnt=2; no stall on the third cycle (lw in WB).
REQ-024 The bench SHALL cover branch after ALU: add $10 then beq rt=$10 -> 1 stall; then mem_rd=10, mem_we=1, and no stall.
REQ-025 The bench SHALL cover the $0 and WB cases:
- Write to $0: lw $0 then beq rs=$0 -> stall=0; ex_we=0.
- WB hit only: wb_rd=5, wb_we=1, beq rs=$5 -> stall=0.
REQ-026 The bench SHALL cover flush versus stall: a load-use condition with id_flush=1 -> stall=0, EX bubble, stall_cnt unchanged.
REQ-027 The bench SHALL cover saturation and reset:
- Preload stall_cnt=16'hFFFE and hold a stall condition for 3 cycles -> stall_cnt ends at 16'hFFFF.
- Drive rst_n=0 for one edge mid-stall -> all outputs are 0 and stall=0.
